// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage hazard/wait requests in, per-stage stall/flush,
// redirect qualifiers and performance counters out.
interface pipe_ctrl_if #(
    parameter int unsigned NSTG  = 5,
    parameter int unsigned CNT_W = 32
);
    logic             ld_use_haz;
    logic             imem_wait;
    logic             mc_busy;
    logic             dmem_wait;
    logic             br_taken_e;
    logic             trap_req;
    logic [NSTG-1:0]  stall;
    logic [NSTG-1:0]  flush;
    logic             redirect;
    logic             redirect_trap;
    logic             trap_busy;
    logic [CNT_W-1:0] perf_stall;
    logic [CNT_W-1:0] perf_flush;

    modport master (
        output ld_use_haz, imem_wait, mc_busy, dmem_wait, br_taken_e, trap_req,
        input  stall, flush, redirect, redirect_trap, trap_busy, perf_stall, perf_flush
    );

    modport slave (
        input  ld_use_haz, imem_wait, mc_busy, dmem_wait, br_taken_e, trap_req,
        output stall, flush, redirect, redirect_trap, trap_busy, perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage requests into a contiguous stall prefix, turns
// taken branches and traps into flush/redirect, and holds fetch after a trap.
module pipe_ctrl #(
    parameter int unsigned NSTG     = 5,
    parameter int unsigned TRAP_LAT = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        grst,
    pipe_ctrl_if.slave  bus
);
    localparam int unsigned ST_F = 0;
    localparam int unsigned ST_D = 1;
    localparam int unsigned ST_E = 2;
    localparam int unsigned ST_M = 3;
    localparam logic [3:0]  HOLD_INIT = 4'(TRAP_LAT - 1);

    typedef enum logic {
        RUN       = 1'b0,
        TRAP_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    logic [NSTG-1:0]  stall_c;
    logic [NSTG-1:0]  flush_c;
    logic             lvl_f, lvl_d, lvl_e, lvl_m;
    logic             run, hold, br_acc, trap_acc;

    always_comb begin
        run  = (state_q == RUN);
        hold = (state_q == TRAP_HOLD);

        // Each level implies every level below it, giving a contiguous prefix.
        lvl_m = bus.dmem_wait;
        lvl_e = bus.mc_busy    | lvl_m;
        lvl_d = bus.ld_use_haz | lvl_e;
        lvl_f = bus.imem_wait  | lvl_d | hold;

        stall_c = '0;
        if (!grst) begin
            stall_c[ST_F] = lvl_f;
            stall_c[ST_D] = lvl_d;
            stall_c[ST_E] = lvl_e;
            stall_c[ST_M] = lvl_m;
        end

        br_acc   = !grst && run && bus.br_taken_e && !stall_c[ST_E];
        trap_acc = !grst && run && bus.trap_req   && !stall_c[ST_M];

        flush_c = '0;
        if (br_acc) begin
            flush_c[ST_F] = 1'b1;
            flush_c[ST_D] = 1'b1;
        end
        if (trap_acc) begin
            flush_c[ST_F] = 1'b1;
            flush_c[ST_D] = 1'b1;
            flush_c[ST_E] = 1'b1;
            flush_c[ST_M] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;

        unique case (state_q)
            RUN: begin
                if (trap_acc) begin
                    state_d = TRAP_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            TRAP_HOLD: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = RUN;
        endcase

        if (stall_c[ST_F] && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + CNT_W'(1);
        if ((flush_c != '0) && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.redirect      = br_acc | trap_acc;
    assign bus.redirect_trap = trap_acc;
    assign bus.trap_busy     = hold;
    assign bus.perf_stall    = perf_stall_q;
    assign bus.perf_flush    = perf_flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second instance with 3-bit counters exercises
// perf counter saturation on the same stimulus.
module tb_pipe_ctrl;
    logic clk;
    logic grst;
    logic ld, imem, mc, dmem, br, trap;

    int unsigned total;
    int unsigned passed;

    pipe_ctrl_if #(.NSTG(5), .CNT_W(32)) u_if ();
    pipe_ctrl_if #(.NSTG(5), .CNT_W(3))  s_if ();

    assign u_if.ld_use_haz = ld;
    assign u_if.imem_wait  = imem;
    assign u_if.mc_busy    = mc;
    assign u_if.dmem_wait  = dmem;
    assign u_if.br_taken_e = br;
    assign u_if.trap_req   = trap;
    assign s_if.ld_use_haz = ld;
    assign s_if.imem_wait  = imem;
    assign s_if.mc_busy    = mc;
    assign s_if.dmem_wait  = dmem;
    assign s_if.br_taken_e = br;
    assign s_if.trap_req   = trap;

    pipe_ctrl #(.NSTG(5), .TRAP_LAT(3), .CNT_W(32)) u_dut (
        .clk  (clk),
        .grst (grst),
        .bus  (u_if.slave)
    );

    pipe_ctrl #(.NSTG(5), .TRAP_LAT(3), .CNT_W(3)) s_dut (
        .clk  (clk),
        .grst (grst),
        .bus  (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; passed = 0;
        grst = 1'b1;
        ld = 0; imem = 1; mc = 0; dmem = 0; br = 0; trap = 1;
        #3;
        chk("rst_stall", 64'(u_if.stall), 64'h0);
        chk("rst_flush", 64'(u_if.flush), 64'h0);
        chk("rst_redirect", 64'(u_if.redirect), 64'h0);
        chk("rst_busy", 64'(u_if.trap_busy), 64'h0);
        chk("rst_perf_stall", 64'(u_if.perf_stall), 64'h0);
        chk("rst_perf_flush", 64'(u_if.perf_flush), 64'h0);
        @(negedge clk);
        grst = 1'b0; imem = 0; trap = 0;

        // imem_wait for 3 cycles
        for (int i = 0; i < 3; i++) begin
            imem = 1; #1;
            chk("imem_stall", 64'(u_if.stall), 64'h01);
            chk("imem_flush", 64'(u_if.flush), 64'h00);
            tick();
        end
        imem = 0;
        chk("imem_perf_stall", 64'(u_if.perf_stall), 64'd3);
        chk("imem_perf_stall_s", 64'(s_if.perf_stall), 64'd3);
        chk("imem_perf_flush", 64'(u_if.perf_flush), 64'd0);

        // load-use hazard with accepted branch
        ld = 1; br = 1; #1;
        chk("ldbr_stall", 64'(u_if.stall), 64'h03);
        chk("ldbr_flush", 64'(u_if.flush), 64'h03);
        chk("ldbr_redirect", 64'(u_if.redirect), 64'h1);
        chk("ldbr_rtrap", 64'(u_if.redirect_trap), 64'h0);
        tick();
        ld = 0; br = 0;
        chk("ldbr_perf_flush", 64'(u_if.perf_flush), 64'd1);
        chk("ldbr_perf_stall", 64'(u_if.perf_stall), 64'd4);

        // branch held while M stalls, accepted on release
        for (int i = 0; i < 2; i++) begin
            dmem = 1; br = 1; #1;
            chk("dbr_stall", 64'(u_if.stall), 64'h0F);
            chk("dbr_redirect", 64'(u_if.redirect), 64'h0);
            chk("dbr_flush", 64'(u_if.flush), 64'h00);
            tick();
        end
        dmem = 0; #1;
        chk("dbr_rel_redirect", 64'(u_if.redirect), 64'h1);
        chk("dbr_rel_flush", 64'(u_if.flush), 64'h03);
        chk("dbr_rel_stall", 64'(u_if.stall), 64'h00);
        tick();
        br = 0; #1;
        chk("dbr_pulse_end", 64'(u_if.redirect), 64'h0);
        chk("dbr_perf_stall", 64'(u_if.perf_stall), 64'd6);
        chk("dbr_perf_flush", 64'(u_if.perf_flush), 64'd2);
        chk("pre_sat_s", 64'(s_if.perf_stall), 64'd6);

        // saturation of the 3-bit counter from all-ones minus 1
        for (int i = 0; i < 3; i++) begin
            imem = 1;
            tick();
            chk("sat_s", 64'(s_if.perf_stall), 64'd7);
            chk("sat_big", 64'(u_if.perf_stall), 64'(7 + i));
        end
        imem = 0;

        // multicycle busy blocks a branch
        mc = 1; br = 1; #1;
        chk("mc_stall", 64'(u_if.stall), 64'h07);
        chk("mc_redirect", 64'(u_if.redirect), 64'h0);
        tick();
        mc = 0; br = 0;

        // trap pulse and hold sequence
        trap = 1; #1;
        chk("trap_flush", 64'(u_if.flush), 64'h0F);
        chk("trap_redirect", 64'(u_if.redirect), 64'h1);
        chk("trap_rtrap", 64'(u_if.redirect_trap), 64'h1);
        chk("trap_stall", 64'(u_if.stall), 64'h00);
        chk("trap_busy_t", 64'(u_if.trap_busy), 64'h0);
        tick();
        trap = 0; #1;
        chk("hold1_busy", 64'(u_if.trap_busy), 64'h1);
        chk("hold1_stall", 64'(u_if.stall), 64'h01);
        chk("hold1_redirect", 64'(u_if.redirect), 64'h0);
        tick();
        br = 1; #1;
        chk("hold2_busy", 64'(u_if.trap_busy), 64'h1);
        chk("hold2_br_redirect", 64'(u_if.redirect), 64'h0);
        chk("hold2_br_flush", 64'(u_if.flush), 64'h00);
        tick();
        br = 0; dmem = 1; #1;
        chk("hold3_busy", 64'(u_if.trap_busy), 64'h1);
        chk("hold3_dmem_stall", 64'(u_if.stall), 64'h0F);
        tick();
        dmem = 0; #1;
        chk("run_busy", 64'(u_if.trap_busy), 64'h0);
        chk("run_stall", 64'(u_if.stall), 64'h00);
        chk("trap_perf_stall", 64'(u_if.perf_stall), 64'd13);
        chk("trap_perf_flush", 64'(u_if.perf_flush), 64'd3);
        tick();

        // held trap waits for M, then reset lands mid-hold
        trap = 1; dmem = 1; #1;
        chk("htrap_stall", 64'(u_if.stall), 64'h0F);
        chk("htrap_redirect", 64'(u_if.redirect), 64'h0);
        chk("htrap_flush", 64'(u_if.flush), 64'h00);
        tick();
        dmem = 0; #1;
        chk("htrap_acc_rtrap", 64'(u_if.redirect_trap), 64'h1);
        chk("htrap_acc_flush", 64'(u_if.flush), 64'h0F);
        tick();
        #1;
        chk("htrap_busy", 64'(u_if.trap_busy), 64'h1);
        chk("htrap_no_redirect", 64'(u_if.redirect), 64'h0);
        tick();
        grst = 1; #1;
        chk("mid_rst_busy", 64'(u_if.trap_busy), 64'h0);
        chk("mid_rst_stall", 64'(u_if.stall), 64'h00);
        chk("mid_rst_flush", 64'(u_if.flush), 64'h00);
        chk("mid_rst_redirect", 64'(u_if.redirect), 64'h0);
        chk("mid_rst_perf_stall", 64'(u_if.perf_stall), 64'd0);
        chk("mid_rst_perf_flush", 64'(u_if.perf_flush), 64'd0);
        chk("mid_rst_perf_s", 64'(s_if.perf_stall), 64'd0);
        trap = 0;
        @(negedge clk);
        grst = 0;
        tick();
        chk("post_rst_busy", 64'(u_if.trap_busy), 64'h0);
        chk("post_rst_stall", 64'(u_if.stall), 64'h00);

        // trap and branch together: trap wins
        trap = 1; br = 1; #1;
        chk("tb_flush", 64'(u_if.flush), 64'h0F);
        chk("tb_redirect", 64'(u_if.redirect), 64'h1);
        chk("tb_rtrap", 64'(u_if.redirect_trap), 64'h1);
        tick();
        trap = 0; br = 0; #1;
        chk("tb_busy", 64'(u_if.trap_busy), 64'h1);
        chk("tb_perf_flush", 64'(u_if.perf_flush), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
